// File: rtl/markov_merge_scheduler_if.sv
// Merge-engine handshake bundle: launch pulse and operands out, completion and merged length back.
// The scheduler drives through the master modport; the engine sits on the slave side.
interface markov_merge_scheduler_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              m_start;
  logic [ADDR_W-1:0] m_a_base;
  logic [ADDR_W-1:0] m_b_base;
  logic [ADDR_W-1:0] m_out_base;
  logic [LEN_W-1:0]  m_a_len;
  logic [LEN_W-1:0]  m_b_len;
  logic              m_done;
  logic [LEN_W-1:0]  m_out_len;

  modport master (
    output m_start, m_a_base, m_b_base, m_out_base, m_a_len, m_b_len,
    input  m_done, m_out_len
  );

  modport slave (
    input  m_start, m_a_base, m_b_base, m_out_base, m_a_len, m_b_len,
    output m_done, m_out_len
  );
endinterface

// File: rtl/markov_merge_scheduler.sv
// Folds up to NUM_LISTS sorted transition lists into one accumulated list by launching pairwise
// merges on the merge engine, ping-ponging the accumulator between two scratch buffers.
module markov_merge_scheduler #(
  parameter int                NUM_LISTS = 8,
  parameter int                IDX_W     = $clog2(NUM_LISTS),
  parameter int                ADDR_W    = 8,
  parameter int                LEN_W     = 8,
  parameter logic [ADDR_W-1:0] BUF0_BASE = 8'h80,
  parameter logic [ADDR_W-1:0] BUF1_BASE = 8'hC0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IDX_W:0]          num_lists,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [IDX_W-1:0]        tbl_idx,
  input  logic [ADDR_W-1:0]       tbl_base,
  input  logic [LEN_W-1:0]        tbl_len,
  markov_merge_scheduler_if.master m_if,
  output logic [ADDR_W-1:0]       result_base,
  output logic [LEN_W-1:0]        result_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_SWAP,
    S_FINISH
  } state_t;

  localparam logic [IDX_W:0] MAX_LISTS = (IDX_W+1)'(NUM_LISTS);
  localparam logic [IDX_W:0] ONE       = (IDX_W+1)'(1);

  state_t              state_q, state_d;
  logic [IDX_W:0]      cnt_q, cnt_d;
  logic [IDX_W:0]      i_q, i_d;
  logic                pp_q, pp_d;
  logic                abort_q, abort_d;
  logic [ADDR_W-1:0]   acc_base_q, acc_base_d;
  logic [LEN_W-1:0]    acc_len_q, acc_len_d;
  logic [IDX_W-1:0]    tbl_idx_q, tbl_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                m_start_q, m_start_d;
  logic [ADDR_W-1:0]   m_a_base_q, m_a_base_d;
  logic [ADDR_W-1:0]   m_b_base_q, m_b_base_d;
  logic [ADDR_W-1:0]   m_out_base_q, m_out_base_d;
  logic [LEN_W-1:0]    m_a_len_q, m_a_len_d;
  logic [LEN_W-1:0]    m_b_len_q, m_b_len_d;
  logic [ADDR_W-1:0]   result_base_q, result_base_d;
  logic [LEN_W-1:0]    result_len_q, result_len_d;

  logic [IDX_W:0]      i_inc;
  logic [LEN_W:0]      len_sum;
  logic                bad_count;

  // One extra bit on the sum exposes an accumulator that would outgrow LEN_W.
  assign i_inc     = i_q + ONE;
  assign len_sum   = {1'b0, acc_len_q} + {1'b0, tbl_len};
  assign bad_count = (num_lists == '0) || (num_lists > MAX_LISTS);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    i_d           = i_q;
    pp_d          = pp_q;
    abort_d       = abort_q;
    acc_base_d    = acc_base_q;
    acc_len_d     = acc_len_q;
    tbl_idx_d     = tbl_idx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    m_start_d     = 1'b0;
    m_a_base_d    = m_a_base_q;
    m_b_base_d    = m_b_base_q;
    m_out_base_d  = m_out_base_q;
    m_a_len_d     = m_a_len_q;
    m_b_len_d     = m_b_len_q;
    result_base_d = result_base_q;
    result_len_d  = result_len_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          acc_base_d = '0;
          acc_len_d  = '0;
          i_d        = '0;
          pp_d       = 1'b0;
          if (bad_count) begin
            abort_d = 1'b1;
            state_d = S_FINISH;
          end else begin
            abort_d   = 1'b0;
            cnt_d     = num_lists;
            tbl_idx_d = '0;
            state_d   = S_FETCH;
          end
        end
      end

      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        if (i_q != '0 && tbl_len != '0 && len_sum[LEN_W]) begin
          abort_d = 1'b1;
          state_d = S_FINISH;
        end else if (i_q != '0 && tbl_len != '0) begin
          m_start_d    = 1'b1;
          m_a_base_d   = acc_base_q;
          m_a_len_d    = acc_len_q;
          m_b_base_d   = tbl_base;
          m_b_len_d    = tbl_len;
          m_out_base_d = pp_q ? BUF1_BASE : BUF0_BASE;
          state_d      = S_ISSUE;
        end else begin
          // First list is adopted as-is; empty later lists are simply skipped.
          if (i_q == '0) begin
            acc_base_d = tbl_base;
            acc_len_d  = tbl_len;
          end
          i_d = i_inc;
          if (i_inc == cnt_q) begin
            state_d = S_FINISH;
          end else begin
            tbl_idx_d = i_inc[IDX_W-1:0];
            state_d   = S_FETCH;
          end
        end
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        if (m_if.m_done) begin
          acc_base_d = m_out_base_q;
          acc_len_d  = m_if.m_out_len;
          state_d    = S_SWAP;
        end
      end

      S_SWAP: begin
        pp_d = ~pp_q;
        i_d  = i_inc;
        if (i_inc == cnt_q) begin
          state_d = S_FINISH;
        end else begin
          tbl_idx_d = i_inc[IDX_W-1:0];
          state_d   = S_FETCH;
        end
      end

      S_FINISH: begin
        done_d        = 1'b1;
        err_d         = abort_q;
        busy_d        = 1'b0;
        result_base_d = acc_base_q;
        result_len_d  = acc_len_q;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      i_q           <= '0;
      pp_q          <= 1'b0;
      abort_q       <= 1'b0;
      acc_base_q    <= '0;
      acc_len_q     <= '0;
      tbl_idx_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      m_start_q     <= 1'b0;
      m_a_base_q    <= '0;
      m_b_base_q    <= '0;
      m_out_base_q  <= '0;
      m_a_len_q     <= '0;
      m_b_len_q     <= '0;
      result_base_q <= '0;
      result_len_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      i_q           <= i_d;
      pp_q          <= pp_d;
      abort_q       <= abort_d;
      acc_base_q    <= acc_base_d;
      acc_len_q     <= acc_len_d;
      tbl_idx_q     <= tbl_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      m_start_q     <= m_start_d;
      m_a_base_q    <= m_a_base_d;
      m_b_base_q    <= m_b_base_d;
      m_out_base_q  <= m_out_base_d;
      m_a_len_q     <= m_a_len_d;
      m_b_len_q     <= m_b_len_d;
      result_base_q <= result_base_d;
      result_len_q  <= result_len_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign tbl_idx         = tbl_idx_q;
  assign result_base     = result_base_q;
  assign result_len      = result_len_q;
  assign m_if.m_start    = m_start_q;
  assign m_if.m_a_base   = m_a_base_q;
  assign m_if.m_b_base   = m_b_base_q;
  assign m_if.m_out_base = m_out_base_q;
  assign m_if.m_a_len    = m_a_len_q;
  assign m_if.m_b_len    = m_b_len_q;

endmodule

// File: tb/tb_markov_merge_scheduler.sv
// Directed bench for markov_merge_scheduler with a registered descriptor table and a
// fixed-latency scripted merge engine.
module tb_markov_merge_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] num_lists;
  logic       busy, done, err;
  logic [2:0] tbl_idx;
  logic [7:0] tbl_base, tbl_len;
  logic [7:0] result_base, result_len;

  markov_merge_scheduler_if #(.ADDR_W(8), .LEN_W(8)) m_if ();

  markov_merge_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_lists   (num_lists),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .tbl_idx     (tbl_idx),
    .tbl_base    (tbl_base),
    .tbl_len     (tbl_len),
    .m_if        (m_if),
    .result_base (result_base),
    .result_len  (result_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Descriptor table: one-cycle registered read.
  logic [7:0] desc_base [0:7];
  logic [7:0] desc_len  [0:7];
  always @(posedge clk) begin
    tbl_base <= desc_base[tbl_idx];
    tbl_len  <= desc_len[tbl_idx];
  end

  // Merge engine: logs each launch, answers three cycles later with a scripted length.
  logic [7:0] out_script [0:31];
  logic [7:0] log_a_base [0:31];
  logic [7:0] log_a_len  [0:31];
  logic [7:0] log_b_base [0:31];
  logic [7:0] log_b_len  [0:31];
  logic [7:0] log_out    [0:31];
  int         ms_count = 0;
  int         eng_cd;
  logic [7:0] pend_len;
  logic       stray_req;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_cd         <= 0;
      m_if.m_done    <= 1'b0;
      m_if.m_out_len <= 8'h00;
      pend_len       <= 8'h00;
    end else begin
      m_if.m_done <= (eng_cd == 1) || stray_req;
      if (eng_cd == 1) m_if.m_out_len <= pend_len;
      if (m_if.m_start) begin
        log_a_base[ms_count] <= m_if.m_a_base;
        log_a_len[ms_count]  <= m_if.m_a_len;
        log_b_base[ms_count] <= m_if.m_b_base;
        log_b_len[ms_count]  <= m_if.m_b_len;
        log_out[ms_count]    <= m_if.m_out_base;
        pend_len             <= out_script[ms_count];
        ms_count             <= ms_count + 1;
        eng_cd               <= 3;
      end else if (eng_cd != 0) begin
        eng_cd <= eng_cd - 1;
      end
    end
  end

  task automatic do_run(input logic [3:0] nl, output int lat, output bit tmo);
    @(negedge clk);
    start = 1'b1;
    num_lists = nl;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    tmo = (done !== 1'b1);
    $display("run nl=%0d lat=%0d err=%b result=%h/%0d merges=%0d", nl, lat, err, result_base, result_len, ms_count);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
    n_checks++; if (m_if.m_start !== 1'b0 || tbl_idx !== 3'd0) begin n_fail++; $display("FAIL reset_mstart_idx got=%b/%0d exp=0/0", m_if.m_start, tbl_idx); end
    n_checks++; if (result_base !== 8'h00 || result_len !== 8'h00 || m_if.m_out_base !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h/%h out=%h exp=00/00 out=00", result_base, result_len, m_if.m_out_base); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle got=%b%b exp=00", busy, done); end
  endtask

  task automatic test_single();
    int lat; bit tmo; int ms0;
    desc_base[0] = 8'h10; desc_len[0] = 8'd5;
    ms0 = ms_count;
    do_run(4'd1, lat, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL single_timeout got=no_done exp=done"); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL single_latency got=%0d exp=4", lat); end
    n_checks++; if (result_base !== 8'h10 || result_len !== 8'd5) begin n_fail++; $display("FAIL single_result got=%h/%0d exp=10/5", result_base, result_len); end
    n_checks++; if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_err_busy got=%b%b exp=00", err, busy); end
    n_checks++; if (ms_count - ms0 !== 0) begin n_fail++; $display("FAIL single_mstarts got=%0d exp=0", ms_count - ms0); end
  endtask

  task automatic test_merge3();
    int lat; bit tmo; int ms0;
    desc_base[0] = 8'h10; desc_len[0] = 8'd4;
    desc_base[1] = 8'h20; desc_len[1] = 8'd3;
    desc_base[2] = 8'h30; desc_len[2] = 8'd2;
    ms0 = ms_count;
    out_script[ms0] = 8'd6; out_script[ms0+1] = 8'd7;
    do_run(4'd3, lat, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL merge3_timeout got=no_done exp=done"); end
    n_checks++; if (ms_count - ms0 !== 2) begin n_fail++; $display("FAIL merge3_mstarts got=%0d exp=2", ms_count - ms0); end
    n_checks++; if (log_a_base[ms0] !== 8'h10 || log_a_len[ms0] !== 8'd4 || log_b_base[ms0] !== 8'h20 || log_b_len[ms0] !== 8'd3 || log_out[ms0] !== 8'h80)
      begin n_fail++; $display("FAIL merge3_first got=A%h/%0d B%h/%0d O%h exp=A10/4 B20/3 O80", log_a_base[ms0], log_a_len[ms0], log_b_base[ms0], log_b_len[ms0], log_out[ms0]); end
    n_checks++; if (log_a_base[ms0+1] !== 8'h80 || log_a_len[ms0+1] !== 8'd6 || log_b_base[ms0+1] !== 8'h30 || log_b_len[ms0+1] !== 8'd2 || log_out[ms0+1] !== 8'hC0)
      begin n_fail++; $display("FAIL merge3_second got=A%h/%0d B%h/%0d O%h exp=A80/6 B30/2 Oc0", log_a_base[ms0+1], log_a_len[ms0+1], log_b_base[ms0+1], log_b_len[ms0+1], log_out[ms0+1]); end
    n_checks++; if (result_base !== 8'hC0 || result_len !== 8'd7 || err !== 1'b0) begin n_fail++; $display("FAIL merge3_result got=%h/%0d err=%b exp=c0/7 err=0", result_base, result_len, err); end
  endtask

  task automatic test_skip();
    int lat; bit tmo; int ms0;
    desc_base[0] = 8'h10; desc_len[0] = 8'd4;
    desc_base[1] = 8'h20; desc_len[1] = 8'd0;
    desc_base[2] = 8'h30; desc_len[2] = 8'd2;
    ms0 = ms_count;
    out_script[ms0] = 8'd9;
    do_run(4'd3, lat, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL skip_timeout got=no_done exp=done"); end
    n_checks++; if (ms_count - ms0 !== 1) begin n_fail++; $display("FAIL skip_mstarts got=%0d exp=1", ms_count - ms0); end
    n_checks++; if (log_a_base[ms0] !== 8'h10 || log_b_base[ms0] !== 8'h30 || log_b_len[ms0] !== 8'd2 || log_out[ms0] !== 8'h80)
      begin n_fail++; $display("FAIL skip_operands got=A%h B%h/%0d O%h exp=A10 B30/2 O80", log_a_base[ms0], log_b_base[ms0], log_b_len[ms0], log_out[ms0]); end
    n_checks++; if (result_base !== 8'h80 || result_len !== 8'd9 || err !== 1'b0) begin n_fail++; $display("FAIL skip_result got=%h/%0d err=%b exp=80/9 err=0", result_base, result_len, err); end
  endtask

  task automatic test_overflow();
    int lat; bit tmo; int ms0;
    desc_base[0] = 8'h40; desc_len[0] = 8'd200;
    desc_base[1] = 8'h50; desc_len[1] = 8'd100;
    ms0 = ms_count;
    do_run(4'd2, lat, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL ovf_timeout got=no_done exp=done"); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%b exp=1", err); end
    n_checks++; if (ms_count - ms0 !== 0) begin n_fail++; $display("FAIL ovf_mstarts got=%0d exp=0", ms_count - ms0); end
    n_checks++; if (result_base !== 8'h40 || result_len !== 8'd200) begin n_fail++; $display("FAIL ovf_result got=%h/%0d exp=40/200", result_base, result_len); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_width got=%b%b exp=00", done, err); end
  endtask

  task automatic test_bad_count();
    int lat; bit tmo; logic [2:0] idx0;
    logic [3:0] bad_vals [0:1];
    bad_vals[0] = 4'd0; bad_vals[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      idx0 = tbl_idx;
      do_run(bad_vals[k], lat, tmo);
      n_checks++; if (tmo || lat !== 2) begin n_fail++; $display("FAIL bad_latency nl=%0d got=%0d exp=2", bad_vals[k], lat); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err nl=%0d got=%b exp=1", bad_vals[k], err); end
      n_checks++; if (result_base !== 8'h00 || result_len !== 8'h00) begin n_fail++; $display("FAIL bad_result nl=%0d got=%h/%0d exp=00/0", bad_vals[k], result_base, result_len); end
      n_checks++; if (tbl_idx !== idx0) begin n_fail++; $display("FAIL bad_tbl_idx nl=%0d got=%0d exp=%0d", bad_vals[k], tbl_idx, idx0); end
    end
  endtask

  task automatic test_reset_in_wait();
    int cnt; int ms0;
    desc_base[0] = 8'h10; desc_len[0] = 8'd4;
    desc_base[1] = 8'h20; desc_len[1] = 8'd3;
    @(negedge clk);
    start = 1'b1; num_lists = 4'd2;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (m_if.m_start !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    n_checks++; if (m_if.m_start !== 1'b1) begin n_fail++; $display("FAIL rst_wait_no_mstart got=0 exp=1"); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || m_if.m_start !== 1'b0) begin n_fail++; $display("FAIL rst_wait_busy got=%b%b exp=00", busy, m_if.m_start); end
    n_checks++; if (m_if.m_a_base !== 8'h00 || m_if.m_a_len !== 8'h00 || m_if.m_b_base !== 8'h00 || m_if.m_out_base !== 8'h00 || tbl_idx !== 3'd0)
      begin n_fail++; $display("FAIL rst_wait_operands got=A%h/%0d B%h O%h idx%0d exp=all0", m_if.m_a_base, m_if.m_a_len, m_if.m_b_base, m_if.m_out_base, tbl_idx); end
    @(negedge clk);
    reset = 1'b0;
    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL stray_done_effect cyc=%0d got=%b%b exp=00", k, busy, done); end
    end
    ms0 = ms_count;
    out_script[ms0] = 8'd8;
    @(negedge clk);
    start = 1'b1; num_lists = 4'd2;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fresh_busy got=%b exp=1", busy); end
    @(negedge clk);
    start = 1'b1; num_lists = 4'd0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 300) begin @(negedge clk); cnt++; end
    $display("run fresh-after-reset err=%b result=%h/%0d merges=%0d", err, result_base, result_len, ms_count - ms0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fresh_timeout got=no_done exp=done"); end
    n_checks++; if (err !== 1'b0 || result_base !== 8'h80 || result_len !== 8'd8) begin n_fail++; $display("FAIL fresh_result got=%h/%0d err=%b exp=80/8 err=0", result_base, result_len, err); end
    n_checks++; if (ms_count - ms0 !== 1) begin n_fail++; $display("FAIL fresh_mstarts got=%0d exp=1", ms_count - ms0); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL busy_start_ignored got=%b%b exp=00", busy, done); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_lists = 4'd0;
    stray_req = 1'b0;
    for (int k = 0; k < 8; k++) begin desc_base[k] = 8'h00; desc_len[k] = 8'h00; end
    for (int k = 0; k < 32; k++) out_script[k] = 8'h00;
    test_reset();
    test_single();
    test_merge3();
    test_skip();
    test_overflow();
    test_bad_count();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
